// File: rtl/im_fmt_pkg.sv
// Shared definitions for the immediate encoder: format codes, opcodes,
// FSM state encoding and a signed-range helper.
package im_fmt_pkg;

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_S  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_U  = 3'b011;
    localparam logic [2:0] FMT_J  = 3'b100;
    localparam logic [2:0] FMT_LI = 3'b101;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LO   = 1'b1
    } state_t;

    // True when v is representable as an nbits-wide two's complement value.
    function automatic logic fits_signed(input logic [31:0] v, input logic [5:0] nbits);
        logic signed [31:0] sv;
        logic [31:0]        top;
        sv  = v;
        top = sv >>> (nbits - 6'd1);
        return (top == 32'h0000_0000) || (top == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/im_pack.sv
// Combinational packer: scatters an immediate into the RV32I I/S/B/U/J
// bit positions of a template word and flags out-of-range immediates.
module im_pack
    import im_fmt_pkg::*;
#(
    parameter int CHECK_RANGE = 1
) (
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [31:0] tmpl,
    output logic [31:0] inst,
    output logic        range_err
);

    logic w_viol;

    // Field scatter and per-format legality of the immediate.
    always_comb begin
        inst   = tmpl;
        w_viol = 1'b0;
        case (fmt)
            FMT_I: begin
                inst   = {imm[11:0], tmpl[19:0]};
                w_viol = !fits_signed(imm, 6'd12);
            end
            FMT_S: begin
                inst   = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
                w_viol = !fits_signed(imm, 6'd12);
            end
            FMT_B: begin
                inst   = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
                w_viol = !fits_signed(imm, 6'd13) || imm[0];
            end
            FMT_U: begin
                inst   = {imm[31:12], tmpl[11:0]};
                w_viol = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                inst   = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
                w_viol = !fits_signed(imm, 6'd21) || imm[0];
            end
            default: begin
                inst   = tmpl;
                w_viol = 1'b0;
            end
        endcase
    end

    assign range_err = (CHECK_RANGE != 0) && w_viol;

endmodule

// File: rtl/im_encoder.sv
// Immediate encoder: valid/ready wrapper around im_pack with a registered
// output stage and the LUI/ADDI expansion of the LI pseudo-format.
module im_encoder
    import im_fmt_pkg::*;
#(
    parameter int CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_tmpl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);

    state_t      r_state, w_state_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_out_inst, w_out_inst_nxt;
    logic        r_out_err, w_out_err_nxt;
    logic        r_out_last, w_out_last_nxt;
    logic [11:0] r_lo, w_lo_nxt;
    logic [4:0]  r_rd, w_rd_nxt;

    logic        w_accept, w_handoff;
    logic [31:0] w_pack_inst, w_addi_inst, w_lui_inst, w_new_inst;
    logic        w_pack_err, w_addi_err, w_new_err, w_new_last, w_two_beat;
    logic [11:0] w_addi_lo;
    logic [4:0]  w_addi_rs1, w_addi_rd;
    logic [19:0] w_hi;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_out_valid && out_ready;

    im_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .tmpl      (in_tmpl),
        .inst      (w_pack_inst),
        .range_err (w_pack_err)
    );

    // ADDI source: the parked low half while splitting, else a fresh rd,x0,lo.
    always_comb begin
        if (r_state == S_LO) begin
            w_addi_lo  = r_lo;
            w_addi_rs1 = r_rd;
            w_addi_rd  = r_rd;
        end else begin
            w_addi_lo  = in_imm[11:0];
            w_addi_rs1 = 5'd0;
            w_addi_rd  = in_tmpl[11:7];
        end
    end

    im_pack #(.CHECK_RANGE(CHECK_RANGE)) u_addi (
        .fmt       (FMT_I),
        .imm       ({{20{w_addi_lo[11]}}, w_addi_lo}),
        .tmpl      ({12'd0, w_addi_rs1, 3'b000, w_addi_rd, OP_IMM}),
        .inst      (w_addi_inst),
        .range_err (w_addi_err)
    );

    // The ADDI sign-extends lo, so the upper part is pre-rounded by imm[11].
    assign w_hi       = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_lui_inst = {w_hi, in_tmpl[11:7], OP_LUI};

    // First beat of a new request, plus whether a second beat will follow.
    always_comb begin
        w_new_inst = in_tmpl;
        w_new_err  = 1'b0;
        w_new_last = 1'b1;
        w_two_beat = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: begin
                if (w_pack_err) begin
                    w_new_inst = in_tmpl;
                    w_new_err  = 1'b1;
                end else begin
                    w_new_inst = w_pack_inst;
                    w_new_err  = 1'b0;
                end
            end
            FMT_LI: begin
                if (fits_signed(in_imm, 6'd12)) begin
                    w_new_inst = w_addi_inst;
                    w_new_err  = w_addi_err;
                end else if (in_imm[11:0] == 12'd0) begin
                    w_new_inst = w_lui_inst;
                end else begin
                    w_new_inst = w_lui_inst;
                    w_new_last = 1'b0;
                    w_two_beat = 1'b1;
                end
            end
            default: begin
                w_new_inst = in_tmpl;
                w_new_err  = 1'b1;
            end
        endcase
    end

    // S_LO spans the whole split LI: beat 1 waiting, ADDI parked in r_lo/r_rd.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_inst_nxt  = r_out_inst;
        w_out_err_nxt   = r_out_err;
        w_out_last_nxt  = r_out_last;
        w_lo_nxt        = r_lo;
        w_rd_nxt        = r_rd;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_inst_nxt  = w_new_inst;
                    w_out_err_nxt   = w_new_err;
                    w_out_last_nxt  = w_new_last;
                    if (w_two_beat) begin
                        w_state_nxt = S_LO;
                        w_lo_nxt    = in_imm[11:0];
                        w_rd_nxt    = in_tmpl[11:7];
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_handoff) begin
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
            end
            S_LO: begin
                if (w_handoff) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b1;
                    w_out_inst_nxt  = w_addi_inst;
                    w_out_err_nxt   = w_addi_err;
                    w_out_last_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, output register and parked ADDI fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'd0;
            r_out_err   <= 1'b0;
            r_out_last  <= 1'b0;
            r_lo        <= 12'd0;
            r_rd        <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_err   <= w_out_err_nxt;
            r_out_last  <= w_out_last_nxt;
            r_lo        <= w_lo_nxt;
            r_rd        <= w_rd_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_err   = r_out_err;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_im_encoder.sv
// Scoreboard bench for im_encoder: two instances (range checks on/off) fed
// the same requests, expected beats from an arithmetic reference model.
module tb_im_encoder;
    import im_fmt_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, v1, v2, out_ready;
    logic [2:0]  fmt;
    logic [31:0] imm, tmpl;
    logic        ir1, ov1, oe1, ol1, ir2, ov2, oe2, ol2;
    logic [31:0] oi1, oi2;

    beat_t q1[$];
    beat_t q2[$];
    int    n_vec = 0, n_bad = 0, ready_mode = 0, cyc = 0;
    bit    mon_en = 1'b0, stall1 = 1'b0, stall2 = 1'b0;
    beat_t prev1, prev2;

    always #5 clk = ~clk;

    im_encoder #(.CHECK_RANGE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1),
        .in_fmt(fmt), .in_imm(imm), .in_tmpl(tmpl),
        .out_valid(ov1), .out_ready(out_ready), .out_inst(oi1),
        .out_err(oe1), .out_last(ol1)
    );

    im_encoder #(.CHECK_RANGE(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2),
        .in_fmt(fmt), .in_imm(imm), .in_tmpl(tmpl),
        .out_valid(ov2), .out_ready(out_ready), .out_inst(oi2),
        .out_err(oe2), .out_last(ol2)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_beat(input string name, input beat_t act, input beat_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got inst=%h err=%b last=%b expected inst=%h err=%b last=%b (t=%0t)",
                     name, act.inst, act.err, act.last, exp.inst, exp.err, exp.last, $time);
        end
    endtask

    // Reference: masks and shifts straight from the field tables, range via integers.
    function automatic void model(input logic [2:0] f, input logic [31:0] im,
                                  input logic [31:0] tp, input bit chk,
                                  output beat_t b0, output beat_t b1, output bit two);
        int          s;
        logic [31:0] ins, rd, hi, lo, addi_x0, lui;
        bit          bad, uns;
        s = $signed(im);
        bad = 1'b0; uns = 1'b0; two = 1'b0; ins = tp;
        b1 = '0;
        if (f == 3'd5) begin
            rd      = (tp >> 7) & 32'h1F;
            lo      = im & 32'hFFF;
            hi      = ((im + 32'h800) >> 12) & 32'hF_FFFF;
            addi_x0 = (lo << 20) | (rd << 7) | 32'h13;
            lui     = (hi << 12) | (rd << 7) | 32'h37;
            if (s >= -2048 && s <= 2047) b0 = {addi_x0, 1'b0, 1'b1};
            else if (lo == 32'd0)        b0 = {lui, 1'b0, 1'b1};
            else begin
                b0  = {lui, 1'b0, 1'b0};
                b1  = {(lo << 20) | (rd << 15) | (rd << 7) | 32'h13, 1'b0, 1'b1};
                two = 1'b1;
            end
        end else begin
            case (f)
                3'd0: begin
                    ins = (tp & 32'h000F_FFFF) | ((im & 32'hFFF) << 20);
                    bad = (s < -2048) || (s > 2047);
                end
                3'd1: begin
                    ins = (tp & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
                    bad = (s < -2048) || (s > 2047);
                end
                3'd2: begin
                    ins = (tp & 32'h01FF_F07F) | (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25)
                        | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7);
                    bad = (s < -4096) || (s > 4095) || ((im & 32'd1) != 32'd0);
                end
                3'd3: begin
                    ins = (tp & 32'hFFF) | (im & 32'hFFFF_F000);
                    bad = (im & 32'hFFF) != 32'd0;
                end
                3'd4: begin
                    ins = (tp & 32'hFFF) | (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                        | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12);
                    bad = (s < -1048576) || (s > 1048575) || ((im & 32'd1) != 32'd0);
                end
                default: uns = 1'b1;
            endcase
            if (uns || (chk && bad)) b0 = {tp, 1'b1, 1'b1};
            else                     b0 = {ins, 1'b0, 1'b1};
        end
    endfunction

    // Present one request to both instances until each has taken it.
    task automatic send(input logic [2:0] f, input logic [31:0] im, input logic [31:0] tp);
        beat_t a0, a1;
        bit    t, d1, d2;
        int    k;
        d1 = 1'b0; d2 = 1'b0; k = 0;
        fmt = f; imm = im; tmpl = tp; v1 = 1'b1; v2 = 1'b1;
        while (!(d1 && d2) && k < 50) begin
            #3;
            if (v1 && ir1) begin
                model(f, im, tp, 1'b1, a0, a1, t);
                q1.push_back(a0);
                if (t) q1.push_back(a1);
                d1 = 1'b1;
            end
            if (v2 && ir2) begin
                model(f, im, tp, 1'b0, a0, a1, t);
                q2.push_back(a0);
                if (t) q2.push_back(a1);
                d2 = 1'b1;
            end
            @(negedge clk);
            k++;
            if (d1) v1 = 1'b0;
            if (d2) v2 = 1'b0;
        end
        if (!(d1 && d2)) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=%b/%b expected acceptance within 50 cycles", ir1, ir2);
            v1 = 1'b0; v2 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        v1 = 1'b0; v2 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_imm();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return $urandom & 32'hFFFF_F000;
            3: return (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'($urandom_range(0, 1));
            default: begin
                case ($urandom_range(0, 9))
                    0: return 32'd2047;
                    1: return 32'd2048;
                    2: return 32'hFFFF_F800;
                    3: return 32'hFFFF_F7FF;
                    4: return 32'd4094;
                    5: return 32'd4096;
                    6: return 32'hFFFF_F000;
                    7: return 32'h000F_FFFE;
                    8: return 32'h0010_0000;
                    default: return 32'hFFF0_0000;
                endcase
            end
        endcase
    endfunction

    // Downstream ready pattern: 0 always, 1 random, 2 one-in-four, 3 never.
    initial forever begin
        @(negedge clk);
        cyc++;
        case (ready_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: out_ready = ((cyc % 4) == 3);
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: handshake expectations follow from the count of undelivered beats.
    initial forever begin
        beat_t e;
        @(negedge clk);
        #2;
        if (mon_en) begin
            check_bit("in_ready", ir1, (q1.size() == 0) || (q1.size() == 1 && out_ready));
            check_bit("out_valid", ov1, q1.size() != 0);
            check_bit("out_valid_nc", ov2, q2.size() != 0);
            if (stall1) check_beat("hold", {oi1, oe1, ol1}, prev1);
            if (stall2) check_beat("hold_nc", {oi2, oe2, ol2}, prev2);
            stall1 = ov1 && !out_ready;
            stall2 = ov2 && !out_ready;
            prev1  = {oi1, oe1, ol1};
            prev2  = {oi2, oe2, ol2};
            if (ov1 && out_ready && q1.size() > 0) begin
                e = q1.pop_front();
                check_beat("beat", {oi1, oe1, ol1}, e);
            end
            if (ov2 && out_ready && q2.size() > 0) begin
                e = q2.pop_front();
                check_beat("beat_nc", {oi2, oe2, ol2}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0;
        fmt = 3'd0; imm = 32'd0; tmpl = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_bit("rst_out_valid", ov1, 1'b0);
        check_bit("rst_out_err", oe1, 1'b0);
        check_bit("rst_out_last", ol1, 1'b0);
        check_bit("rst_out_inst_zero", oi1 == 32'd0, 1'b1);
        check_bit("rst_in_ready", ir1, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send(FMT_I,  32'hFFFF_F800, 32'h0000_0513);
        send(FMT_B,  32'hFFFF_FFFC, 32'h0000_0063);
        send(FMT_B,  32'h0000_0801, 32'h0000_0063);
        send(FMT_U,  32'h0000_1001, 32'h0000_0537);
        send(FMT_LI, 32'h1234_5FFF, 32'h0000_0500);
        send(FMT_LI, 32'h0000_1000, 32'h0000_0500);
        send(FMT_LI, 32'h0000_07FF, 32'h0000_0500);
        send(3'b110, 32'h0000_1234, 32'hABCD_EF01);
        send(3'b111, 32'h0000_0004, 32'h1357_9BDF);
        send(FMT_J,  32'h000F_FFFE, 32'h0000_006F);
        send(FMT_S,  32'hFFFF_F801, 32'h0000_2023);
        idle(4);

        ready_mode = 2;
        send(FMT_LI, 32'h1234_5FFF, 32'h0000_0500);
        idle(12);
        ready_mode = 0;
        idle(2);

        ready_mode = 3;
        send(FMT_LI, 32'h1234_5FFF, 32'h0000_0500);
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_li_valid", ov1, 1'b0);
        check_bit("rst_mid_li_valid_nc", ov2, 1'b0);
        q1.delete();
        q2.delete();
        stall1 = 1'b0;
        stall2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        idle(6);

        for (int i = 0; i < 400; i++) begin
            if ((i % 50) == 0) ready_mode = $urandom_range(0, 2);
            send(3'($urandom_range(0, 7)), rnd_imm(), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        ready_mode = 0;
        idle(20);
        check_bit("drained", q1.size() == 0, 1'b1);
        check_bit("drained_nc", q2.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
